// File: rtl/vga_pattern_gen.sv
// VGA timing generator with four selectable test patterns.
// Counters describe the pixel being registered; every output lags them by one pix_en stage.
module vga_pattern_gen #(
    parameter int COLOR_W  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               btn_rst,
    input  logic               pix_en,
    input  logic [1:0]         mode,
    output logic               vga_h_sync,
    output logic               vga_v_sync,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        MODE_SOLID    = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_GRADIENT = 2'd3
    } mode_e;

    logic [HW-1:0]      h_cnt_q, h_cnt_d;
    logic [VW-1:0]      v_cnt_q, v_cnt_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    mode_e              mode_q, mode_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic               hs_q, hs_d, vs_q, vs_d;
    logic               fs_q, fs_d;

    logic               h_wrap, v_wrap, frame_end, active;
    logic [2:0]         bar_idx;
    logic [HW-1:0]      grad_sum;
    logic [COLOR_W-1:0] pat_r, pat_g, pat_b;

    assign h_wrap    = (h_cnt_q == H_LAST);
    assign v_wrap    = (v_cnt_q == V_LAST);
    assign frame_end = h_wrap && v_wrap;
    assign active    = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    assign grad_sum  = h_cnt_q + HW'(frame_cnt_q);

    // Bar index by threshold compare; anything past the seventh boundary lands in bar 7.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_cnt_q >= HW'(k * BAR_W)) bar_idx = 3'(k);
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pat_r = '0;
        pat_g = '0;
        pat_b = '0;
        if (active) begin
            case (mode_q)
                MODE_SOLID: begin
                    pat_r = '1;
                    pat_g = '1;
                    pat_b = '1;
                end
                MODE_BARS: begin
                    pat_r = {COLOR_W{~bar_idx[1]}};
                    pat_g = {COLOR_W{~bar_idx[2]}};
                    pat_b = {COLOR_W{~bar_idx[0]}};
                end
                MODE_CHECKER: begin
                    if (!(h_cnt_q[5] ^ v_cnt_q[5])) begin
                        pat_r = '1;
                        pat_g = '1;
                        pat_b = '1;
                    end
                end
                MODE_GRADIENT: begin
                    pat_r = grad_sum[COLOR_W+5:6];
                    pat_g = grad_sum[COLOR_W+5:6];
                    pat_b = grad_sum[COLOR_W+5:6];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        mode_d      = mode_q;
        r_d         = r_q;
        g_d         = g_q;
        b_d         = b_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        // A single-clock pulse, so it is not held across idle clocks like the other outputs.
        fs_d        = pix_en && (h_cnt_q == '0) && (v_cnt_q == '0);
        if (pix_en) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
            if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
            if (frame_end) begin
                mode_d      = mode_e'(mode);
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
            r_d  = pat_r;
            g_d  = pat_g;
            b_d  = pat_b;
            hs_d = ((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
            vs_d = ((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge btn_rst) begin
        if (!btn_rst) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            mode_q      <= MODE_SOLID;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            hs_q        <= ~SYNC_POL;
            vs_q        <= ~SYNC_POL;
            fs_q        <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            fs_q        <= fs_d;
        end
    end

    assign vga_h_sync  = hs_q;
    assign vga_v_sync  = vs_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: four instances share clock/pix_en (default horizontal timing, short frame)
// so every pattern mode and both sync polarities are observed within a few frames.
`timescale 1ns/1ps
module tb_vga_pattern_gen;

    localparam int CW      = 4;
    localparam int VA      = 34;
    localparam int VF      = 1;
    localparam int VS      = 2;
    localparam int VB      = 1;
    localparam int HT      = 800;
    localparam int VT      = VA + VF + VS + VB;  // 38 lines
    localparam int LIMIT   = 40000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          btn_rst, pix_en;
    logic [1:0]    mode_a, mode_b, mode_c;

    logic          a_hs, a_vs, a_fs, b_hs, b_vs, b_fs, c_hs, c_vs, c_fs, p_hs, p_vs, p_fs;
    logic [CW-1:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b, p_r, p_g, p_b;

    vga_pattern_gen #(.COLOR_W(CW), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB))
    u_dut (.clk(clk), .btn_rst(btn_rst), .pix_en(pix_en), .mode(mode_a),
           .vga_h_sync(a_hs), .vga_v_sync(a_vs), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
           .frame_start(a_fs));

    vga_pattern_gen #(.COLOR_W(CW), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB))
    u_bars (.clk(clk), .btn_rst(btn_rst), .pix_en(pix_en), .mode(mode_b),
            .vga_h_sync(b_hs), .vga_v_sync(b_vs), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
            .frame_start(b_fs));

    vga_pattern_gen #(.COLOR_W(CW), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB))
    u_grad (.clk(clk), .btn_rst(btn_rst), .pix_en(pix_en), .mode(mode_c),
            .vga_h_sync(c_hs), .vga_v_sync(c_vs), .vga_r(c_r), .vga_g(c_g), .vga_b(c_b),
            .frame_start(c_fs));

    vga_pattern_gen #(.COLOR_W(CW), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                      .SYNC_POL(1'b1))
    u_pol (.clk(clk), .btn_rst(btn_rst), .pix_en(pix_en), .mode(2'd0),
           .vga_h_sync(p_hs), .vga_v_sync(p_vs), .vga_r(p_r), .vga_g(p_g), .vga_b(p_b),
           .frame_start(p_fs));

    int   n_tests     = 0;
    int   n_fail      = 0;
    int   px          = 0;
    int   py          = 0;
    int   total_steps = 0;
    int   fs_step     = 0;
    int   gap         = 4;
    int   fs_count    = 0;
    logic fs_first, fs_late;

    always @(negedge clk) if (a_fs === 1'b1) fs_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (pixel %0d,%0d)", tag, got, exp, px, py);
        end
    endtask

    // Registers pixel (px,py) to the outputs, then advances the model position.
    task automatic step();
        pix_en = 1'b1;
        @(negedge clk);
        pix_en   = 1'b0;
        fs_first = a_fs;
        repeat (gap - 1) @(negedge clk);
        fs_late = a_fs;
        total_steps++;
        px++;
        if (px == HT) begin
            px = 0;
            py = (py == VT - 1) ? 0 : py + 1;
        end
    endtask

    // Leaves the outputs showing pixel (x,y).
    task automatic goto(input int x, input int y);
        int n = 0;
        while (!(px == x && py == y) && n < LIMIT) begin
            step();
            n++;
        end
        if (n >= LIMIT) begin
            n_tests++;
            n_fail++;
            $display("FAIL goto_bound: target %0d,%0d not reached in %0d steps", x, y, LIMIT);
        end
        step();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        btn_rst = 1'b0;
        pix_en  = 1'b0;
        mode_a  = 2'd0;
        mode_b  = 2'd1;
        mode_c  = 2'd3;
        repeat (3) @(negedge clk);

        check("rst_rgb",     {a_r, a_g, a_b}, 12'h000);
        check("rst_hs",      a_hs, 1'b1);
        check("rst_vs",      a_vs, 1'b1);
        check("rst_fs",      {a_fs, b_fs, c_fs, p_fs}, 4'b0000);
        check("rst_pol",     {p_hs, p_vs}, 2'b00);
        check("rst_sync_bc", {b_hs, b_vs, c_hs, c_vs}, 4'hF);

        btn_rst = 1'b1;
        @(negedge clk);

        // Frame 0, one pixel every 4th clock.
        step();
        fs_step = total_steps;
        check("f0_00_rgb",   {a_r, a_g, a_b}, 12'hFFF);
        check("f0_00_bars",  {b_r, b_g, b_b}, 12'hFFF);
        check("f0_00_grad",  {c_r, c_g, c_b}, 12'hFFF);
        check("f0_00_pol",   {p_r, p_g, p_b}, 12'hFFF);
        check("f0_fs_pulse", fs_first, 1'b1);
        check("f0_fs_width", fs_late, 1'b0);
        check("f0_fs_all",   {b_fs, c_fs, p_fs}, 3'b000);
        goto(655, 0); check("hs_655", a_hs, 1'b1);
        goto(656, 0); check("hs_656", a_hs, 1'b0);
        check("pol_hs_656", p_hs, 1'b1);
        goto(751, 0); check("hs_751", a_hs, 1'b0);
        goto(752, 0); check("hs_752", a_hs, 1'b1);
        goto(656, 1); check("hs_period", a_hs, 1'b0);

        gap = 1;
        goto(639, 5);  check("f0_639_5", {a_r, a_g, a_b}, 12'hFFF);
        goto(640, 5);  check("f0_blank", {a_r, a_g, a_b}, 12'h000);
        goto(0, 10);   mode_a = 2'd2;
        goto(32, 20);  check("midframe_white", {a_r, a_g, a_b}, 12'hFFF);
        goto(799, 34); check("vs_34", a_vs, 1'b1);
        goto(0, 35);   check("vs_35", a_vs, 1'b0);
        check("pol_vs_35", p_vs, 1'b1);
        goto(799, 36); check("vs_36", a_vs, 1'b0);
        goto(0, 37);   check("vs_37", a_vs, 1'b1);

        // Frame 1: checkerboard / bars / gradient with frame_cnt=1.
        goto(0, 0);
        check("f1_fs",        fs_first, 1'b1);
        check("frame_len",    total_steps - fs_step, 30400);
        check("f1_chk_00",    {a_r, a_g, a_b}, 12'hFFF);
        check("f1_bars_0",    {b_r, b_g, b_b}, 12'hFFF);
        check("f1_grad_0",    {c_r, c_g, c_b}, 12'h000);
        goto(1, 0);
        check("f1_fs_off",    a_fs, 1'b0);
        check("fs_count",     fs_count, 2);
        goto(31, 0);  check("f1_chk_31",   {a_r, a_g, a_b}, 12'hFFF);
        goto(32, 0);  check("f1_chk_32",   {a_r, a_g, a_b}, 12'h000);
        goto(63, 0);  check("f1_grad_63",  {c_r, c_g, c_b}, 12'h111);
        goto(64, 0);  check("f1_grad_64",  {c_r, c_g, c_b}, 12'h111);
        goto(79, 0);  check("f1_bars_79",  {b_r, b_g, b_b}, 12'hFFF);
        goto(80, 0);  check("f1_bars_80",  {b_r, b_g, b_b}, 12'hFF0);
        goto(400, 0); check("f1_bars_400", {b_r, b_g, b_b}, 12'hF00);
        goto(639, 0);
        check("f1_bars_639", {b_r, b_g, b_b}, 12'h000);
        check("f1_grad_639", {c_r, c_g, c_b}, 12'hAAA);
        goto(640, 0); check("f1_grad_blank", {c_r, c_g, c_b}, 12'h000);
        goto(32, 32); check("f1_chk_32_32", {a_r, a_g, a_b}, 12'hFFF);
        goto(31, 33); check("f1_chk_31_33", {a_r, a_g, a_b}, 12'h000);

        // Frame 2: gradient with frame_cnt=2, then an asynchronous reset mid-frame.
        goto(61, 0);  check("f2_grad_61", {c_r, c_g, c_b}, 12'h000);
        goto(62, 0);  check("f2_grad_62", {c_r, c_g, c_b}, 12'h111);
        goto(300, 2); check("f2_bars_300", {b_r, b_g, b_b}, 12'h0F0);
        #2 btn_rst = 1'b0;
        #1;
        check("arst_rgb",  {b_r, b_g, b_b}, 12'h000);
        check("arst_hs",   {a_hs, a_vs}, 2'b11);
        check("arst_pol",  {p_hs, p_vs}, 2'b00);
        check("arst_fs",   a_fs, 1'b0);
        @(negedge clk);
        btn_rst = 1'b1;
        px = 0;
        py = 0;
        step();
        check("post_rst_rgb",  {a_r, a_g, a_b}, 12'hFFF);
        check("post_rst_grad", {c_r, c_g, c_b}, 12'hFFF);
        check("post_rst_fs",   fs_first, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL expose parameters (name, default, meaning): COLOR_W 4 bits per colour channel; H_ACTIVE 640; H_FP 16; H_SYNC 96; H_BP 48; V_ACTIVE 480; V_FP 10; V_SYNC 2; V_BP 33; SYNC_POL 0 (0 = sync active-low, 1 = active-high).
REQ-002 SHALL derive H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; counter widths SHALL be $clog2 of each total.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 btn_rst  in  1  reset, asynchronous assert, active-low.
REQ-005 pix_en  in  1  pixel strobe; counters and outputs advance only on clk edges where pix_en=1.
REQ-006 mode  in  2  pattern select: 0 solid white, 1 colour bars, 2 checkerboard, 3 scrolling gradient.
REQ-007 vga_h_sync  out  1  registered horizontal sync, polarity per SYNC_POL.
REQ-008 vga_v_sync  out  1  registered vertical sync, polarity per SYNC_POL.
REQ-009 vga_r, vga_g, vga_b  out  COLOR_W each  registered colour.
REQ-010 frame_start  out  1  one-clk pulse coincident with output of pixel (0,0).

Function
REQ-011 h_cnt SHALL count 0..H_TOTAL-1 per pix_en, wrapping to 0; v_cnt SHALL increment when h_cnt wraps, counting 0..V_TOTAL-1 and wrapping to 0.
REQ-012 Active region SHALL be h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-013 h sync SHALL be asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); v sync for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); asserted level = SYNC_POL.
REQ-014 All outputs SHALL be registered with exactly one pix_en-qualified stage of latency relative to the counter value they describe; syncs and colour SHALL stay mutually aligned.
REQ-015 Outside the active region vga_r/g/b SHALL be 0 regardless of mode.
REQ-016 mode SHALL be sampled into mode_q only on the pix_en edge where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1; mode changes mid-frame SHALL NOT alter the current frame.
REQ-017 Mode 0: all channels all-ones.
REQ-018 Mode 1: bar index = h_cnt/(H_ACTIVE/8), bars 0..7 = white, yellow, cyan, green, magenta, red, blue, black; each channel all-ones or 0; last bar absorbs any remainder.
REQ-019 Mode 2: all channels all-ones when h_cnt[5]^v_cnt[5]=0, else 0 (32x32 squares, top-left white).
REQ-020 Mode 3: all channels = bits [COLOR_W+5:6] of (h_cnt + frame_cnt), sum taken modulo 2^(counter width).
REQ-021 frame_cnt SHALL be 8-bit, incremented on the same edge that samples mode, wrapping 255->0.
REQ-022 frame_start SHALL be high for exactly one clk, on the edge the (0,0) pixel is registered to the outputs.
REQ-023 With pix_en held 0, all state and outputs SHALL hold.

Reset
REQ-024 While btn_rst=0: h_cnt, v_cnt, frame_cnt, mode_q = 0; vga_r/g/b = 0; frame_start = 0; vga_h_sync and vga_v_sync = ~SYNC_POL (deasserted).
REQ-025 Reset asserted mid-line or mid-frame SHALL take effect immediately without waiting for clk; after release, first pix_en edge SHALL output pixel (0,0) with mode_q=0 (white) and frame_start=1.

Verification
REQ-026 Defaults, pix_en every 4th clk, mode=0 -> h sync period 800 pixels, low for 96 starting at pixel 656; v sync low for 2 lines starting at line 490; frame = 420000 pixels.
REQ-027 mode=1 -> pixel x=0 F/F/F, x=80 F/F/0, x=400 F/0/0, x=639 0/0/0; x=640 all 0 (blanking).
REQ-028 mode=2 -> (0,0) F, (32,0) 0, (32,32) F, (31,33) 0.
REQ-029 mode=3, frame_cnt=0 -> x=0 value 0, x=64 value 1, x=639 value 9; next frame (frame_cnt=1) x=63 value 1.
REQ-030 mode switched 0->2 at line 100 -> rest of frame stays white; next frame checkerboard; frame_start pulses once per frame.
REQ-031 btn_rst pulsed low at pixel (300,200) -> outputs immediately 0 colour, syncs deasserted; after release first visible pixel is (0,0) white; SYNC_POL=1 build shows inverted sync levels.
